// File: rtl/fft_io_controller.sv
// fft_io_controller: I/O-side master of the FFT sample RAM.
// Loads one frame of N complex samples from the input stream into RAM two per
// cycle, pulses fft_start, waits for fft_done, then reads the results back in
// natural order and streams them out with out_last on the final sample.
// Optional build macro: BITREV_LOAD_EN -- LOAD write addresses are bit-reversed
// over address_width bits so the FFT core sees in-place DIT input order.
module fft_io_controller #(
  parameter int N             = 32,
  parameter int word_size     = 16,
  parameter int address_width = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*word_size-1:0]     in_sample,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*word_size-1:0]     out_sample,
  output logic                       out_last,
  output logic                       fft_start,
  input  logic                       fft_done,
  output logic                       io_wr_en,
  output logic [address_width-1:0]   io_wr_address1,
  output logic [address_width-1:0]   io_wr_address2,
  output logic [2*word_size-1:0]     io_wr_sample1,
  output logic [2*word_size-1:0]     io_wr_sample2,
  output logic [address_width-1:0]   io_rd_address1,
  output logic [address_width-1:0]   io_rd_address2,
  input  logic [2*word_size-1:0]     io_rd_sample1,
  input  logic [2*word_size-1:0]     io_rd_sample2,
  output logic                       busy
);

  localparam int SW = 2 * word_size;
  localparam logic [address_width-1:0] LAST_SAMPLE = address_width'(N - 1);
  localparam logic [address_width-1:0] LAST_PAIR   = address_width'(N / 2 - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [address_width-1:0] sample_count_reg;
  logic [SW-1:0]            pair_hold_reg;
  logic [address_width-1:0] pair_count_reg;
  logic                     phase_reg;      // 0: presenting even sample, 1: odd sample
  logic                     rd_issue_reg;   // read addresses on the bus this cycle
  logic                     rd_data_reg;    // read data on the bus this cycle
  logic [SW-1:0]            second_reg;     // odd sample of the pair awaiting its turn

  logic in_fire;
  logic out_fire;
  logic load_done;
  logic unload_done;

  assign in_ready    = (state_reg == LOAD);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign load_done   = in_fire && (sample_count_reg == LAST_SAMPLE);
  assign unload_done = out_fire && phase_reg && (pair_count_reg == LAST_PAIR);

  // Natural-order addresses of the pair completed by the current odd sample
  logic [address_width-1:0] nat_even;
  logic [address_width-1:0] nat_odd;
  logic [address_width-1:0] load_addr_even;
  logic [address_width-1:0] load_addr_odd;

  assign nat_even = {sample_count_reg[address_width-1:1], 1'b0};
  assign nat_odd  = {sample_count_reg[address_width-1:1], 1'b1};

`ifdef BITREV_LOAD_EN
  // Mirror the address bits so the frame lands in bit-reversed order
  for (genvar gi = 0; gi < address_width; gi++) begin : g_bitrev
    assign load_addr_even[gi] = nat_even[address_width-1-gi];
    assign load_addr_odd[gi]  = nat_odd[address_width-1-gi];
  end
`else
  assign load_addr_even = nat_even;
  assign load_addr_odd  = nat_odd;
`endif

  // Read address of the pair following the one currently being emitted
  logic [address_width-1:0] pair_plus1;
  assign pair_plus1 = pair_count_reg + address_width'(1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: terminal counts and fft_done move the frame through its phases
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (load_done)   state_next = COMPUTE;
      COMPUTE: if (fft_done)    state_next = UNLOAD;
      UNLOAD:  if (unload_done) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // LOAD datapath: hold even sample, write the pair when its odd partner arrives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_count_reg <= '0;
      pair_hold_reg    <= '0;
      io_wr_en         <= 1'b0;
      io_wr_address1   <= '0;
      io_wr_address2   <= '0;
      io_wr_sample1    <= '0;
      io_wr_sample2    <= '0;
    end else begin
      io_wr_en <= 1'b0;
      if (in_fire) begin
        if (!sample_count_reg[0]) begin
          pair_hold_reg <= in_sample;
        end else begin
          io_wr_en       <= 1'b1;
          io_wr_address1 <= load_addr_even;
          io_wr_address2 <= load_addr_odd;
          io_wr_sample1  <= pair_hold_reg;
          io_wr_sample2  <= in_sample;
        end
        sample_count_reg <= load_done ? '0 : sample_count_reg + address_width'(1);
      end
    end
  end

  // COMPUTE handshake: start once the final pair write has reached RAM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fft_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // The only write that can occur in COMPUTE is the final pair of the frame
      fft_start <= (state_reg == COMPUTE) && io_wr_en;
      busy      <= (state_next == COMPUTE);
    end
  end

  // UNLOAD datapath: one pair read at a time, emitted even sample first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_count_reg <= '0;
      phase_reg      <= 1'b0;
      rd_issue_reg   <= 1'b0;
      rd_data_reg    <= 1'b0;
      io_rd_address1 <= '0;
      io_rd_address2 <= '0;
      second_reg     <= '0;
      out_valid      <= 1'b0;
      out_sample     <= '0;
      out_last       <= 1'b0;
    end else begin
      rd_issue_reg <= 1'b0;
      rd_data_reg  <= rd_issue_reg;

      if ((state_reg == COMPUTE) && fft_done) begin
        pair_count_reg <= '0;
        io_rd_address1 <= address_width'(0);
        io_rd_address2 <= address_width'(1);
        rd_issue_reg   <= 1'b1;
      end

      // Pair arrives from RAM: even sample goes straight to the output
      if (rd_data_reg) begin
        out_sample <= io_rd_sample1;
        second_reg <= io_rd_sample2;
        out_valid  <= 1'b1;
        out_last   <= 1'b0;
        phase_reg  <= 1'b0;
      end

      if (out_fire) begin
        if (!phase_reg) begin
          out_sample <= second_reg;
          out_last   <= (pair_count_reg == LAST_PAIR);
          phase_reg  <= 1'b1;
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          phase_reg <= 1'b0;
          if (pair_count_reg == LAST_PAIR) begin
            pair_count_reg <= '0;
          end else begin
            // Buffer is now empty, so the next pair can be fetched
            pair_count_reg <= pair_plus1;
            io_rd_address1 <= {pair_plus1[address_width-2:0], 1'b0};
            io_rd_address2 <= {pair_plus1[address_width-2:0], 1'b1};
            rd_issue_reg   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_io_controller.sv
// tb_fft_io_controller: self-checking bench for fft_io_controller (N=32).
// A behavioural RAM sits on the io_* ports; a stand-in FFT core transforms the
// RAM contents with a known per-address mask when it signals fft_done. The
// expected output frame is computed from the loaded samples, the load address
// rule (natural, or bit-reversed with BITREV_LOAD_EN) and that mask.
module tb_fft_io_controller;

  localparam int N  = 32;
  localparam int WS = 16;
  localparam int AW = 5;
  localparam int SW = 2 * WS;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_sample;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sample;
  logic          out_last;
  logic          fft_start;
  logic          fft_done;
  logic          io_wr_en;
  logic [AW-1:0] io_wr_address1, io_wr_address2;
  logic [SW-1:0] io_wr_sample1, io_wr_sample2;
  logic [AW-1:0] io_rd_address1, io_rd_address2;
  logic [SW-1:0] io_rd_sample1, io_rd_sample2;
  logic          busy;

  fft_io_controller #(.N(N), .word_size(WS), .address_width(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sample      (in_sample),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sample     (out_sample),
    .out_last       (out_last),
    .fft_start      (fft_start),
    .fft_done       (fft_done),
    .io_wr_en       (io_wr_en),
    .io_wr_address1 (io_wr_address1),
    .io_wr_address2 (io_wr_address2),
    .io_wr_sample1  (io_wr_sample1),
    .io_wr_sample2  (io_wr_sample2),
    .io_rd_address1 (io_rd_address1),
    .io_rd_address2 (io_rd_address2),
    .io_rd_sample1  (io_rd_sample1),
    .io_rd_sample2  (io_rd_sample2),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference helpers ----------------
  function automatic int load_addr(input int k);
`ifdef BITREV_LOAD_EN
    int r;
    r = 0;
    for (int b = 0; b < AW; b++)
      if (((k >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
    return r;
`else
    return k;
`endif
  endfunction

  function automatic logic [SW-1:0] core_mask(input int a);
    logic [SW-1:0] m;
    m = 32'h5A00_0000 ^ (SW'(a) * 32'h0001_0003);
    return m;
  endfunction

  logic [SW-1:0] frame   [N];
  logic [SW-1:0] exp_out [N];

  // ---------------- RAM model and stand-in FFT core ----------------
  logic [SW-1:0] ram [N];
  logic          core_apply;

  always @(posedge clk) begin
    if (core_apply) begin
      for (int i = 0; i < N; i++) ram[i] <= ram[i] ^ core_mask(i);
    end else if (io_wr_en) begin
      ram[io_wr_address1] <= io_wr_sample1;
      ram[io_wr_address2] <= io_wr_sample2;
    end
    io_rd_sample1 <= ram[io_rd_address1];
    io_rd_sample2 <= ram[io_rd_address2];
  end

  // ---------------- monitors (record only) ----------------
  typedef struct {
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [SW-1:0] d1;
    logic [SW-1:0] d2;
  } wr_t;

  wr_t wr_q[$];
  int  cyc = 0;
  int  start_count = 0;
  int  start_cyc = 0;
  int  last_wr_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (io_wr_en) begin
      wr_t w;
      w.a1 = io_wr_address1;
      w.a2 = io_wr_address2;
      w.d1 = io_wr_sample1;
      w.d2 = io_wr_sample2;
      wr_q.push_back(w);
      last_wr_cyc = cyc;
    end
    if (fft_start) begin
      start_count = start_count + 1;
      start_cyc   = cyc;
    end
  end

  // ---------------- stimulus helpers (no comparisons) ----------------
  int in_timeouts = 0;

  task automatic send_sample(input logic [SW-1:0] s);
    int guard;
    guard = 0;
    in_valid  = 1'b1;
    in_sample = s;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) in_timeouts++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Fill frame (ramp or random), compute expected outputs, stream it in
  task automatic load_frame(input bit ramp, input bit gaps);
    for (int k = 0; k < N; k++) frame[k] = ramp ? SW'(k) : SW'($urandom);
    for (int k = 0; k < N; k++) exp_out[load_addr(k)] = frame[k] ^ core_mask(load_addr(k));
    for (int k = 0; k < N; k++) begin
      send_sample(frame[k]);
      if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
    end
  endtask

  task automatic pulse_done(input bit apply);
    fft_done   = 1'b1;
    core_apply = apply;
    @(negedge clk);
    fft_done   = 1'b0;
    core_apply = 1'b0;
  endtask

  logic [SW-1:0] got_data [N];
  logic          got_last [N];
  int            n_out;
  int            stall_breaks;

  // Drain one frame with out_ready high ready_pct percent of cycles
  task automatic collect_frame(input int ready_pct);
    int            guard;
    logic          pv, pr, pl;
    logic [SW-1:0] ps;
    n_out = 0; stall_breaks = 0; guard = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; ps = '0;
    while (n_out < N && guard < 3000) begin
      if (pv && !pr && (!out_valid || out_sample !== ps || out_last !== pl))
        stall_breaks++;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (out_valid && out_ready) begin
        got_data[n_out] = out_sample;
        got_last[n_out] = out_last;
        n_out++;
      end
      pv = out_valid; pr = out_ready; ps = out_sample; pl = out_last;
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (io_wr_en !== 1'b0)  begin bad++; $display("FAIL reset_wr_en got=%b want=0", io_wr_en); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (fft_start !== 1'b0) begin bad++; $display("FAIL reset_fft_start got=%b want=0", fft_start); end
    total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    $display("test_reset: reset released, idle outputs checked");
  endtask

  task automatic test_load_ramp();
    int n_wr;
    wr_q.delete();
    start_count = 0;
    load_frame(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    total++; if (wr_q.size() !== N / 2) begin bad++; $display("FAIL ramp_write_count got=%0d want=%0d", wr_q.size(), N / 2); end
    n_wr = (wr_q.size() < N / 2) ? wr_q.size() : N / 2;
    for (int j = 0; j < n_wr; j++) begin
      total++;
      if (wr_q[j].a1 !== AW'(load_addr(2 * j)) || wr_q[j].a2 !== AW'(load_addr(2 * j + 1)) ||
          wr_q[j].d1 !== frame[2 * j] || wr_q[j].d2 !== frame[2 * j + 1]) begin
        bad++;
        $display("FAIL ramp_write[%0d] got=%0d/%0d %h/%h want=%0d/%0d %h/%h", j,
                 wr_q[j].a1, wr_q[j].a2, wr_q[j].d1, wr_q[j].d2,
                 load_addr(2 * j), load_addr(2 * j + 1), frame[2 * j], frame[2 * j + 1]);
      end
      $display("ramp write %0d: addr %0d/%0d data %h/%h", j, wr_q[j].a1, wr_q[j].a2, wr_q[j].d1, wr_q[j].d2);
    end
    total++; if (start_count !== 1) begin bad++; $display("FAIL ramp_start_count got=%0d want=1", start_count); end
    total++; if (start_cyc - last_wr_cyc !== 1) begin bad++; $display("FAIL ramp_start_timing got=%0d want=1", start_cyc - last_wr_cyc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ramp_in_ready_compute got=%b want=0", in_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ramp_busy got=%b want=1", busy); end
    total++; if (in_timeouts !== 0) begin bad++; $display("FAIL ramp_input_timeout got=%0d want=0", in_timeouts); end
    // Input offered during COMPUTE must be refused without side effects
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_sample = SW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (wr_q.size() !== N / 2) begin bad++; $display("FAIL compute_input_ignored got=%0d want=%0d", wr_q.size(), N / 2); end
    total++; if (start_count !== 1) begin bad++; $display("FAIL compute_single_start got=%0d want=1", start_count); end
  endtask

  // Finish the frame in flight: fft_done after a delay, then drain and check
  task automatic test_compute_unload(input int delay, input int ready_pct, input string tag);
    repeat (delay) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_before_done got=%b want=1", tag, busy); end
    pulse_done(1'b1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_after_done got=%b want=0", tag, busy); end
    collect_frame(ready_pct);
    total++; if (n_out !== N) begin bad++; $display("FAIL %s_out_count got=%0d want=%0d", tag, n_out, N); end
    for (int j = 0; j < n_out; j++) begin
      total++;
      if (got_data[j] !== exp_out[j] || got_last[j] !== (j == N - 1)) begin
        bad++;
        $display("FAIL %s_out[%0d] got=%h last=%b want=%h last=%b", tag, j, got_data[j], got_last[j], exp_out[j], (j == N - 1));
      end
      $display("%s out %0d: %h last=%b", tag, j, got_data[j], got_last[j]);
    end
    total++; if (stall_breaks !== 0) begin bad++; $display("FAIL %s_stall_stable got=%0d want=0", tag, stall_breaks); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready_after got=%b want=1", tag, in_ready); end
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_no_extra_output got=%b want=0", tag, out_valid); end
  endtask

  task automatic test_done_ignored_in_load();
    pulse_done(1'b0);
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL done_in_load_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL done_in_load_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL done_in_load_out_valid got=%b want=0", out_valid); end
    $display("test_done_ignored_in_load: stray fft_done checked");
  endtask

  task automatic test_reset_abort();
    int n_wr;
    for (int k = 0; k < 10; k++) send_sample(SW'($urandom));
    // Sample 9 completed a pair, so a write is on the bus right now
    total++; if (io_wr_en !== 1'b1) begin bad++; $display("FAIL abort_write_pending got=%b want=1", io_wr_en); end
    reset = 1'b0;
    #1;
    total++; if (io_wr_en !== 1'b0) begin bad++; $display("FAIL abort_wr_en_async got=%b want=0", io_wr_en); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr_q.delete();
    start_count = 0;
    load_frame(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    total++; if (wr_q.size() !== N / 2) begin bad++; $display("FAIL abort_write_count got=%0d want=%0d", wr_q.size(), N / 2); end
    n_wr = (wr_q.size() < N / 2) ? wr_q.size() : N / 2;
    for (int j = 0; j < n_wr; j++) begin
      total++;
      if (wr_q[j].a1 !== AW'(load_addr(2 * j)) || wr_q[j].a2 !== AW'(load_addr(2 * j + 1)) ||
          wr_q[j].d1 !== frame[2 * j] || wr_q[j].d2 !== frame[2 * j + 1]) begin
        bad++;
        $display("FAIL abort_write[%0d] got=%0d/%0d %h/%h want=%0d/%0d %h/%h", j,
                 wr_q[j].a1, wr_q[j].a2, wr_q[j].d1, wr_q[j].d2,
                 load_addr(2 * j), load_addr(2 * j + 1), frame[2 * j], frame[2 * j + 1]);
      end
    end
    total++; if (start_count !== 1) begin bad++; $display("FAIL abort_start_count got=%0d want=1", start_count); end
    $display("test_reset_abort: new frame reloaded after mid-frame reset");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      wr_q.delete();
      start_count = 0;
      load_frame(1'b0, 1'b1);
      repeat (2) @(negedge clk);
      total++; if (wr_q.size() !== N / 2) begin bad++; $display("FAIL b2b_write_count got=%0d want=%0d", wr_q.size(), N / 2); end
      total++; if (start_count !== 1) begin bad++; $display("FAIL b2b_start_count got=%0d want=1", start_count); end
      test_compute_unload($urandom_range(2, 20), 70, "b2b");
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_sample  = '0;
    out_ready  = 1'b0;
    fft_done   = 1'b0;
    core_apply = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_ramp();
    test_compute_unload(44, 100, "ramp");
    test_done_ignored_in_load();
    test_reset_abort();
    test_compute_unload(30, 50, "bp");
    test_back_to_back();
    total++; if (in_timeouts !== 0) begin bad++; $display("FAIL input_timeouts got=%0d want=0", in_timeouts); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
